// File: rtl/mult_pkg.sv
// Shared types and constants for the mult_shift_add_8 shift-add multiplier.
package mult_pkg;

  localparam int WIDTH_C = 8;
  localparam logic [2:0] CNT_LAST = 3'd7;

  // ula_8_bits control word that selects F = A plus B with no carry in
  localparam logic [3:0] ULA_S_ADD    = 4'b1001;
  localparam logic       ULA_M_ARITH  = 1'b0;
  localparam logic       ULA_CIN_NONE = 1'b0;

  typedef enum logic [1:0] {IDLE, ADD, SHIFT, DONE} mult_state_t;

endpackage

// File: rtl/ula_8_bits.sv
// 8-bit ALU in the 74181 style: m=1 selects logic functions, m=0 arithmetic with active-high carry in.
module ula_8_bits (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [3:0] s,
  input  logic       m,
  input  logic       cin,
  output logic [7:0] f,
  output logic       cout
);

  logic [8:0] result;

  // Arithmetic results carry out in bit 8; logic results never produce a carry
  always_comb begin
    result = 9'd0;
    if (m) begin
      case (s)
        4'b0000: result = {1'b0, ~a};
        4'b0001: result = {1'b0, ~(a | b)};
        4'b0011: result = 9'd0;
        4'b0100: result = {1'b0, ~(a & b)};
        4'b0101: result = {1'b0, ~b};
        4'b0110: result = {1'b0, a ^ b};
        4'b1001: result = {1'b0, ~(a ^ b)};
        4'b1010: result = {1'b0, b};
        4'b1011: result = {1'b0, a & b};
        4'b1100: result = 9'h0FF;
        4'b1110: result = {1'b0, a | b};
        default: result = {1'b0, a};
      endcase
    end else begin
      case (s)
        4'b0110: result = {1'b0, a} + {1'b0, ~b} + {8'd0, cin};
        4'b1001: result = {1'b0, a} + {1'b0, b} + {8'd0, cin};
        4'b1100: result = {1'b0, a} + {1'b0, a} + {8'd0, cin};
        4'b1111: result = {1'b0, a} + 9'h0FF + {8'd0, cin};
        default: result = {1'b0, a} + {8'd0, cin};
      endcase
    end
  end

  assign f    = result[7:0];
  assign cout = result[8];

endmodule

// File: rtl/mult_shift_add_8.sv
// Sequential 8x8 unsigned shift-add multiplier (16-bit product) around one ula_8_bits adder.
// Define MULT_SKIP_ADD_EN to fold the shift into ADD when the multiplier bit is zero.
module mult_shift_add_8
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_C
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p
);

  if (WIDTH != WIDTH_C) begin : g_width_check
    $error("mult_shift_add_8: only WIDTH=8 is supported");
  end

  mult_state_t        state_q, state_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic               c_q, c_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0]   aluF;
  logic               aluCout;
  logic               doShift;

  ula_8_bits u_ula (
    .a    (a_q),
    .b    (m_q),
    .s    (ULA_S_ADD),
    .m    (ULA_M_ARITH),
    .cin  (ULA_CIN_NONE),
    .f    (aluF),
    .cout (aluCout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      m_q     <= '0;
      a_q     <= '0;
      c_q     <= 1'b0;
      q_q     <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      a_q     <= a_d;
      c_q     <= c_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
    end
  end

  // The shift step is shared by SHIFT and, when enabled, by a skipped ADD
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    a_d     = a_q;
    c_d     = c_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    doShift = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          m_d     = a;
          q_d     = b;
          a_d     = '0;
          c_d     = 1'b0;
          cnt_d   = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        if (q_q[0]) begin
          {c_d, a_d} = {aluCout, aluF};
          state_d    = SHIFT;
        end else begin
`ifdef MULT_SKIP_ADD_EN
          doShift = 1'b1;
`else
          state_d = SHIFT;
`endif
        end
      end
      SHIFT:   doShift = 1'b1;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (doShift) begin
      {c_d, a_d, q_d} = {1'b0, c_q, a_q, q_q[WIDTH-1:1]};
      if (cnt_q == CNT_LAST) begin
        state_d = DONE;
        p_d     = {a_d, q_d};
      end else begin
        cnt_d   = cnt_q + 3'd1;
        state_d = ADD;
      end
    end
  end

  assign busy = (state_q == ADD) || (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign p    = p_q;

endmodule

// File: tb/tb_mult_shift_add_8.sv
// Self-checking bench for mult_shift_add_8: per-cycle timeline model plus literal product/latency checks.
// Build with MULT_SKIP_ADD_EN defined to exercise the skip-add latency figures.
module tb_mult_shift_add_8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  a = 8'd0;
  logic [7:0]  b = 8'd0;
  logic        busy;
  logic        done;
  logic [15:0] p;

  int checkCount = 0;
  int errCount   = 0;

  always #5 clk = ~clk;

  mult_shift_add_8 dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .p     (p)
  );

  // Timeline model: an accepted start gives a fixed number of busy cycles, then one done cycle
  logic        expBusy = 1'b0;
  logic        expDone = 1'b0;
  logic [15:0] expP    = 16'd0;
  logic [15:0] pendP   = 16'd0;
  int          remaining = 0;

  function automatic int busyCyclesFor(input logic [7:0] mult);
`ifdef MULT_SKIP_ADD_EN
    return 8 + $countones(mult);
`else
    return 16;
`endif
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      expBusy   = 1'b0;
      expDone   = 1'b0;
      expP      = 16'd0;
      remaining = 0;
    end else if (remaining > 0) begin
      remaining = remaining - 1;
      if (remaining == 0) begin
        expBusy = 1'b0;
        expDone = 1'b1;
        expP    = pendP;
      end
    end else if (expDone) begin
      expDone = 1'b0;
    end else if (start) begin
      pendP     = {8'd0, a} * {8'd0, b};
      remaining = busyCyclesFor(b);
      expBusy   = 1'b1;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual != expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("model_busy", int'(busy), int'(expBusy));
    checkOutput("model_done", int'(done), int'(expDone));
    checkOutput("model_p", int'(p), int'(expP));
  end

  task automatic applyStimulus(input logic [7:0] opA, input logic [7:0] opB,
                               input logic [15:0] pLit, input int cycDef,
                               input int cycSkip, input int rePulse);
    int expCyc;
    int doneCyc  = 0;
    int busyCyc  = 0;
    int extraDone = 0;
`ifdef MULT_SKIP_ADD_EN
    expCyc = cycSkip;
`else
    expCyc = cycDef;
`endif
    @(posedge clk); #2;
    a = opA; b = opB; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    for (int k = 1; k <= 40 && doneCyc == 0; k++) begin
      @(negedge clk);
      if (done) doneCyc = k;
      else if (busy) busyCyc++;
      if (doneCyc == 0) begin
        @(posedge clk); #2;
        if (k + 1 == rePulse) begin
          start = 1'b1; a = 8'd7; b = 8'd7;
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    if (doneCyc == 0) begin
      checkCount++;
      errCount++;
      $display("[TB] FAIL done_timeout: no done for a=%0d b=%0d within 40 cycles", opA, opB);
    end else begin
      checkOutput("done_cycle", doneCyc, expCyc);
      checkOutput("busy_cycles", busyCyc, expCyc - 1);
      checkOutput("product", int'(p), int'(pLit));
    end
    repeat (20) begin
      @(negedge clk);
      if (done) extraDone++;
    end
    checkOutput("single_done", extraDone, 0);
    checkOutput("product_held", int'(p), int'(pLit));
  endtask

  task automatic holdStartRun(input logic [7:0] opA, input logic [7:0] opB,
                              input logic [15:0] pLit, input int firstDef, input int firstSkip,
                              input int secondDef, input int secondSkip);
    int n = 0;
    int cyc0 = 0;
    int cyc1 = 0;
    int exp0, exp1;
`ifdef MULT_SKIP_ADD_EN
    exp0 = firstSkip; exp1 = secondSkip;
`else
    exp0 = firstDef; exp1 = secondDef;
`endif
    @(posedge clk); #2;
    a = opA; b = opB; start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 80 && n < 2; k++) begin
      @(negedge clk);
      if (done) begin
        if (n == 0) cyc0 = k; else cyc1 = k;
        n++;
      end
    end
    start = 1'b0;
    if (n < 2) begin
      checkCount++;
      errCount++;
      $display("[TB] FAIL b2b_timeout: saw %0d of 2 done pulses", n);
    end else begin
      checkOutput("b2b_first_done", cyc0, exp0);
      checkOutput("b2b_second_done", cyc1, exp1);
      checkOutput("b2b_product", int'(p), int'(pLit));
    end
    repeat (25) @(negedge clk);
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    checkOutput("reset_p", int'(p), 0);
    @(posedge clk); #2;
    rst = 1'b0;

    applyStimulus(8'd13,  8'd11,  16'h008F, 17, 12, 0);
    applyStimulus(8'd255, 8'd255, 16'hFE01, 17, 17, 0);
    applyStimulus(8'd0,   8'd200, 16'h0000, 17, 12, 0);
    applyStimulus(8'd200, 8'd0,   16'h0000, 17, 9,  0);
    applyStimulus(8'd1,   8'hA5,  16'h00A5, 17, 13, 0);
    applyStimulus(8'd3,   8'd4,   16'h000C, 17, 10, 5);

    // Abort a long run with reset in its eighth cycle
    @(posedge clk); #2;
    a = 8'd255; b = 8'd255; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (7) begin
      @(posedge clk); #2;
    end
    checkOutput("pre_abort_busy", int'(busy), 1);
    rst = 1'b1;
    #1;
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_done", int'(done), 0);
    checkOutput("abort_p", int'(p), 0);
    @(posedge clk); #2;
    rst = 1'b0;

    applyStimulus(8'd2,   8'd3,   16'h0006, 17, 11, 0);
    applyStimulus(8'd9,   8'h01,  16'h0009, 17, 10, 0);
    applyStimulus(8'd9,   8'hFF,  16'h08F7, 17, 17, 0);
    holdStartRun(8'd2, 8'd5, 16'h000A, 17, 11, 35, 23);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errCount);
    $finish;
  end

endmodule
